tx_pulser_ch: RTL and testbench
===============================

Name: tx_pulser_ch

Overview:
- Per-channel transmit beamforming unit; the transmit-side counterpart of the receive DBF channel.
- On a transmit trigger, it looks up the per-scan-line transmit focusing delay in a loadable delay LUT and counts that many clocks.
- It then drives a bipolar pulse burst (pulse_p/pulse_n) to the channel's pulser driver.
- It raises tx_en from trigger to end of burst. The receive channel uses ~tx_en as its input-valid qualifier.

Parameters:
ADDR_WD, 7, LUT address width (128 scan lines)
DLY_WD, 12, transmit delay width in clocks (max 4095 clk = 102.4 us at 40 MHz)
NCYC_WD, 4, width of burst cycle count
HALF_PER, 4, clocks per half pulse period (5 MHz pulse at 40 MHz clk); must be >= 1

Ports:
clk  input  1  40 MHz system clock
rst_n  input  1  asynchronous active-low reset
lut_addr  input  ADDR_WD  delay LUT write address
lut_we  input  1  delay LUT write enable
lut_din  input  DLY_WD  delay LUT write data (clocks)
line_idx  input  ADDR_WD  scan line to fire; sampled with tx_trig
num_cycles  input  NCYC_WD  burst length in full pulse periods; sampled with tx_trig
tx_trig  input  1  start transmit (single-cycle pulse or level; acted on only in IDLE)
abort  input  1  synchronous abort of current transmit
pulse_p  output  1  positive pulser drive, registered
pulse_n  output  1  negative pulser drive, registered
tx_en  output  1  high from trigger until burst end, registered
tx_busy  output  1  high whenever FSM is not IDLE
tx_done  output  1  one-cycle completion strobe

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Counters are cleared.
  - LUT contents are not reset (RAM); software loads the LUT before the first trigger.
- Delay LUT:
  - 2^ADDR_WD x DLY_WD single-port RAM.
  - Write on lut_we at the clk edge.
  - Synchronous read with 1-cycle latency.
  - Read-first: a write to the address being read in the same cycle returns the old data.
  - Writes are allowed in any state.
- FSM states: IDLE, FETCH, DELAY, PULSE, DONE.
- IDLE:
  - On tx_trig=1 at edge k, latch line_idx and num_cycles, and issue the LUT read.
  - Go to FETCH.
  - tx_en and tx_busy are 1 from edge k.
- FETCH: load the delay counter with the LUT data D; go to DELAY.
- DELAY:
  - Decrement each clock; leave DELAY when the counter reaches 0.
  - The first pulse_p=1 appears at edge k+2+D+1 = k+3+D, so the absolute delay is D + 3 clocks after trigger.
  - This 3-clock fixed offset is identical on all channels and therefore cancels across the aperture.
  - If num_cycles=0, go to DONE instead of PULSE; no pulses are emitted.
- PULSE:
  - Each period is pulse_p=1 for HALF_PER clocks, then pulse_n=1 for HALF_PER clocks.
  - Repeat num_cycles times; burst length = 2*HALF_PER*num_cycles clocks.
  - pulse_p and pulse_n are never 1 in the same cycle, including at transitions and abort.
  - At the final clock of the last negative half, go to DONE.
- DONE:
  - pulse_p=pulse_n=0, tx_en=0, tx_done=1 for exactly one cycle, tx_busy=1.
  - Next state is IDLE.
- tx_trig while not in IDLE is ignored; it is not queued.
- tx_trig in the same cycle the FSM returns to IDLE from DONE is ignored. The earliest re-trigger is the cycle after tx_done.
- abort=1 in any non-IDLE state:
  - At the next edge: pulse_p=pulse_n=0, tx_en=0, tx_busy=0, FSM to IDLE, no tx_done.
  - abort has priority over tx_trig in the same cycle.
  - abort in IDLE has no effect.
- Reset mid-burst: outputs drop to 0 immediately (async); no tx_done.
- Width rules:
  - The delay counter is DLY_WD bits and loads from the LUT unsigned.
  - The half-period counter is ceil(log2(HALF_PER))+1 bits.
  - The cycle counter is NCYC_WD bits; no wrap is possible because the loaded value is at most 2^NCYC_WD-1.
  - D=0 is legal: the first pulse_p is at k+3.
  - D=2^DLY_WD-1 must not overflow.

Test Plan:
1. Write LUT[5]=10, trigger line_idx=5, num_cycles=2 at edge k -> tx_en=1 from k; pulse_p=1 at k+13..k+16, pulse_n=1 at k+17..k+20, pulse_p k+21..k+24, pulse_n k+25..k+28; tx_en=0 and tx_done=1 at k+29; tx_busy=0 at k+30.
2. LUT[0]=0 and LUT[127]=4095, fire each with num_cycles=1 -> first pulse_p at k+3 and k+4098 respectively; burst of 8 clocks each; no counter overflow.
3. num_cycles=0, LUT[3]=7 -> no pulse_p/pulse_n ever; tx_done at k+10; tx_en high k..k+9.
4. Assert tx_trig every cycle during a burst, and on the cycle tx_done is 1 -> only one burst per tx_done; a new burst starts only when triggered in IDLE after tx_done.
5. abort in DELAY, in mid pulse_p half, and same cycle as tx_trig in IDLE -> outputs 0 at the next edge, no tx_done, FSM IDLE; abort+trig in IDLE starts a transmit (abort ignored in IDLE).
6. Write LUT[9]=20 on the same cycle as FETCH reading line 9 (old value 6) -> delay 6 used; next trigger uses 20. Also: rst_n low mid-burst -> pulse_p/pulse_n/tx_en low asynchronously; monitor that pulse_p&pulse_n is never 1 throughout.

Source files
------------

// File: rtl/tx_pulser_ch.sv
// tx_pulser_ch: per-channel transmit beamforming pulser.
//
// A trigger looks up this channel's focusing delay for the requested scan line
// in a loadable delay LUT. The unit waits that many clocks, then drives a
// bipolar burst of num_cycles full periods on pulse_p/pulse_n.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   lut_addr/we/din   delay LUT write port (writes allowed in any state)
//   line_idx          scan line to fire, sampled with tx_trig
//   num_cycles        burst length in full pulse periods, sampled with tx_trig
//   tx_trig           transmit request
//   abort             synchronous abort of the current transmit
//   pulse_p, pulse_n  registered pulser drives (never both high)
//   tx_en             registered, high from trigger to end of burst
//   tx_busy           high whenever the FSM is not IDLE
//   tx_done           one-cycle completion strobe
//   dbg_state         current FSM state encoding (IDLE=0)
//
// Handshake: tx_trig is a request that is accepted only when tx_busy is low
// (FSM in IDLE). A request made while busy is dropped, not queued. The earliest
// accepted re-trigger is the cycle after tx_done.
module tx_pulser_ch #(
  parameter int ADDR_WD  = 7,
  parameter int DLY_WD   = 12,
  parameter int NCYC_WD  = 4,
  parameter int HALF_PER = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic               lut_we,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic [ADDR_WD-1:0] line_idx,
  input  logic [NCYC_WD-1:0] num_cycles,
  input  logic               tx_trig,
  input  logic               abort,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               tx_en,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [2:0]         dbg_state
);

  localparam int HC_WD = $clog2(HALF_PER) + 1;
  localparam logic [HC_WD-1:0] HC_LAST = HC_WD'(HALF_PER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               fetch_ph_q, fetch_ph_d;
  logic [ADDR_WD-1:0] line_q, line_d;
  logic [NCYC_WD-1:0] ncyc_q, ncyc_d;
  logic [DLY_WD-1:0]  dly_q, dly_d;
  logic [HC_WD-1:0]   half_q, half_d;
  logic [NCYC_WD-1:0] cyc_q, cyc_d;
  logic               neg_q, neg_d;
  logic               pulse_p_d, pulse_n_d, tx_en_d, tx_done_d;

  // Delay LUT: single-port style RAM, read-first, 1-cycle read latency.
  // The read is issued in the first FETCH cycle; the second FETCH cycle
  // loads the counter. This gives the fixed trigger-to-pulse offset of 3.
  logic [DLY_WD-1:0] mem [2**ADDR_WD];
  logic [DLY_WD-1:0] rd_q;
  logic              rd_en;

  assign rd_en = (state_q == S_FETCH) && !fetch_ph_q;

  always_ff @(posedge clk) begin
    if (lut_we) mem[lut_addr] <= lut_din;
    if (rd_en)  rd_q <= mem[line_q];
  end

  assign tx_busy   = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = fetch_ph_q;
    line_d     = line_q;
    ncyc_d     = ncyc_q;
    dly_d      = dly_q;
    half_d     = half_q;
    cyc_d      = cyc_q;
    neg_d      = neg_q;
    pulse_p_d  = pulse_p;
    pulse_n_d  = pulse_n;
    tx_en_d    = tx_en;
    tx_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_trig) begin
          state_d    = S_FETCH;
          line_d     = line_idx;
          ncyc_d     = num_cycles;
          fetch_ph_d = 1'b0;
          tx_en_d    = 1'b1;
        end
      end
      S_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          dly_d   = rd_q;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        // Exit test is on the current value, so the count never underflows
        // even for the largest delay.
        if (dly_q == '0) begin
          if (ncyc_q == '0) begin
            state_d   = S_DONE;
            tx_en_d   = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            state_d   = S_PULSE;
            pulse_p_d = 1'b1;
            half_d    = HC_LAST;
            cyc_d     = ncyc_q;
            neg_d     = 1'b0;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (half_q != '0) begin
          half_d = half_q - 1'b1;
        end else if (!neg_q) begin
          // Positive half ends: swap drives in one registered step so the
          // two outputs never overlap.
          neg_d     = 1'b1;
          pulse_p_d = 1'b0;
          pulse_n_d = 1'b1;
          half_d    = HC_LAST;
        end else if (cyc_q == NCYC_WD'(1)) begin
          state_d   = S_DONE;
          pulse_n_d = 1'b0;
          tx_en_d   = 1'b0;
          tx_done_d = 1'b1;
        end else begin
          cyc_d     = cyc_q - 1'b1;
          neg_d     = 1'b0;
          pulse_n_d = 1'b0;
          pulse_p_d = 1'b1;
          half_d    = HC_LAST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pulse_p_d = 1'b0;
        pulse_n_d = 1'b0;
        tx_en_d   = 1'b0;
      end
    endcase

    // Abort wins over everything, including a same-cycle trigger; it has no
    // meaning in IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      pulse_p_d = 1'b0;
      pulse_n_d = 1'b0;
      tx_en_d   = 1'b0;
      tx_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_ph_q <= 1'b0;
      line_q     <= '0;
      ncyc_q     <= '0;
      dly_q      <= '0;
      half_q     <= '0;
      cyc_q      <= '0;
      neg_q      <= 1'b0;
      pulse_p    <= 1'b0;
      pulse_n    <= 1'b0;
      tx_en      <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      line_q     <= line_d;
      ncyc_q     <= ncyc_d;
      dly_q      <= dly_d;
      half_q     <= half_d;
      cyc_q      <= cyc_d;
      neg_q      <= neg_d;
      pulse_p    <= pulse_p_d;
      pulse_n    <= pulse_n_d;
      tx_en      <= tx_en_d;
      tx_done    <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_tx_pulser_ch.sv
// Testbench for tx_pulser_ch: table of transmit scenarios with hand-derived
// expected pulse start / done offsets, expanded into per-cycle expected output
// vectors on a queue, plus hand sequences for abort and asynchronous reset.
module tb_tx_pulser_ch;

  localparam int HP = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  lut_addr;
  logic        lut_we;
  logic [11:0] lut_din;
  logic [6:0]  line_idx;
  logic [3:0]  num_cycles;
  logic        tx_trig;
  logic        abort;
  logic        pulse_p, pulse_n, tx_en, tx_busy, tx_done;
  logic [2:0]  dbg_state;

  tx_pulser_ch #(.ADDR_WD(7), .DLY_WD(12), .NCYC_WD(4), .HALF_PER(HP)) dut (
    .clk(clk), .rst_n(rst_n),
    .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
    .line_idx(line_idx), .num_cycles(num_cycles),
    .tx_trig(tx_trig), .abort(abort),
    .pulse_p(pulse_p), .pulse_n(pulse_n), .tx_en(tx_en),
    .tx_busy(tx_busy), .tx_done(tx_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];   // {pulse_p, pulse_n, tx_en, tx_busy, tx_done}

  typedef struct {
    logic [6:0]  line;
    logic        load;       // write dly into LUT[line] before firing
    logic [11:0] dly;
    logic [3:0]  ncyc;
    logic        hold;       // keep tx_trig high through the done cycle
    logic        abort_trig; // abort together with trigger while IDLE
    logic        collide;    // write 20 to LUT[line] in the FETCH cycle
    int          exp_first;  // offset of first pulse_p from trigger edge
    int          exp_done;   // offset of tx_done from trigger edge
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {pulse_p, pulse_n, tx_en, tx_busy, tx_done};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic lut_write(input logic [6:0] a, input logic [11:0] d);
    @(negedge clk);
    lut_addr = a; lut_din = d; lut_we = 1'b1;
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  task automatic fire(input int id, input vec_t r);
    logic [4:0] e;
    int rel;
    if (r.load) lut_write(r.line, r.dly);
    @(negedge clk);
    line_idx = r.line; num_cycles = r.ncyc; tx_trig = 1'b1; abort = r.abort_trig;
    for (int t = 0; t <= r.exp_done + 2; t++) begin
      if (t == r.exp_done)      e = 5'b00011;
      else if (t > r.exp_done)  e = 5'b00000;
      else if (t < r.exp_first) e = 5'b00110;
      else begin
        rel = (t - r.exp_first) % (2 * HP);
        e = (rel < HP) ? 5'b10110 : 5'b01110;
      end
      exp_q.push_back(e);
    end
    for (int t = 0; t <= r.exp_done + 2; t++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d t%0d", id, t), 32'(outs()), 32'(e));
      chk($sformatf("row%0d t%0d overlap", id, t), 32'(pulse_p & pulse_n), 32'd0);
      @(negedge clk);
      abort    = 1'b0;
      tx_trig  = r.hold && (t <= r.exp_done);
      lut_we   = r.collide && (t == 0);
      lut_addr = r.line;
      lut_din  = 12'd20;
    end
    lut_we = 1'b0;
    tx_trig = 1'b0;
  endtask

  task automatic abort_seq(input string nm, input logic [6:0] line, input logic [11:0] d,
                           input logic [3:0] n, input int at, input logic exp_p);
    lut_write(line, d);
    @(negedge clk);
    line_idx = line; num_cycles = n; tx_trig = 1'b1;
    for (int t = 0; t <= at; t++) begin
      @(posedge clk); #1;
      if (t == at) chk({nm, " before"}, 32'({pulse_p, tx_en, tx_busy}), 32'({exp_p, 2'b11}));
      @(negedge clk);
      tx_trig = 1'b0;
      abort = (t == at);
    end
    @(posedge clk); #1;
    chk({nm, " outs"}, 32'(outs()), 32'd0);
    chk({nm, " state"}, 32'(dbg_state), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      chk({nm, " stays idle"}, 32'(outs()), 32'd0);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    vec_t r;
    int d, n;
    rst_n = 1'b0; lut_addr = '0; lut_we = 1'b0; lut_din = '0;
    line_idx = '0; num_cycles = '0; tx_trig = 1'b0; abort = 1'b0;

    //          line load dly  ncyc hold abt col first done
    tbl[0] = '{7'd5,   1'b1, 12'd10,   4'd2, 1'b0, 1'b0, 1'b0, 13,   29};
    tbl[1] = '{7'd0,   1'b1, 12'd0,    4'd1, 1'b0, 1'b0, 1'b0, 3,    11};
    tbl[2] = '{7'd127, 1'b1, 12'd4095, 4'd1, 1'b0, 1'b0, 1'b0, 4098, 4106};
    tbl[3] = '{7'd3,   1'b1, 12'd7,    4'd0, 1'b0, 1'b0, 1'b0, 10,   10};
    tbl[4] = '{7'd8,   1'b1, 12'd5,    4'd1, 1'b1, 1'b0, 1'b0, 8,    16};
    tbl[5] = '{7'd4,   1'b1, 12'd2,    4'd1, 1'b0, 1'b1, 1'b0, 5,    13};
    tbl[6] = '{7'd9,   1'b1, 12'd6,    4'd1, 1'b0, 1'b0, 1'b1, 9,    17};
    tbl[7] = '{7'd9,   1'b0, 12'd0,    4'd1, 1'b0, 1'b0, 1'b0, 23,   31};
    for (int i = 8; i < 10; i++) begin
      d = $urandom_range(0, 40);
      n = $urandom_range(1, 3);
      tbl[i] = '{7'($urandom_range(10, 120)), 1'b1, 12'(d), 4'(n), 1'b0, 1'b0, 1'b0,
                 3 + d, 3 + d + 2 * HP * n};
    end

    // reset state
    #2;
    chk("reset outs", 32'(outs()), 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset idle", 32'(outs()), 32'd0);

    for (int i = 0; i < 10; i++) fire(i, tbl[i]);

    abort_seq("abort in delay", 7'd20, 12'd30, 4'd2, 5, 1'b0);
    abort_seq("abort in pulse_p", 7'd21, 12'd2, 4'd3, 6, 1'b1);

    // asynchronous reset mid-burst (LUT[5] still holds 10)
    @(negedge clk);
    line_idx = 7'd5; num_cycles = 4'd2; tx_trig = 1'b1;
    for (int t = 0; t <= 15; t++) begin
      @(posedge clk); #1;
      chk("rst seq overlap", 32'(pulse_p & pulse_n), 32'd0);
      if (t < 15) begin
        @(negedge clk);
        tx_trig = 1'b0;
      end
    end
    chk("rst seq pulse_p before", 32'({pulse_p, tx_en}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outs", 32'(outs()), 32'd0);
    chk("async reset state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    chk("held reset outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      chk("no done after reset", 32'(outs()), 32'd0);
    end

    // LUT survives reset: same line fires with the same timing
    r = tbl[0];
    r.load = 1'b0;
    fire(10, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
